// File: rtl/class_search_ctrl.sv
// Associative-search sequencer: sweeps the class-vector ROM, accumulates per-class
// Hamming distance against a buffered query, and reports the closest class.
module class_search_ctrl #(
  parameter int NUM_CLASSES = 8,
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_W     = 64,
  parameter int CLASS_W     = 3,
  parameter int FIDX_W      = 2,
  parameter int DIST_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               query_wr_en,
  input  logic [FIDX_W-1:0]  query_wr_idx,
  input  logic [FRAME_W-1:0] query_wr_data,
  input  logic               start,
  output logic [CLASS_W-1:0] frame_id,
  output logic [FIDX_W-1:0]  frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  output logic               busy,
  output logic               done,
  output logic [CLASS_W-1:0] best_class,
  output logic [DIST_W-1:0]  best_dist
);

  localparam int PCNT_W = $clog2(FRAME_W + 1);
  localparam logic [FIDX_W-1:0]  LAST_FIDX  = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state, state_next;

  logic [FRAME_W-1:0] query [NUM_FRAMES];

  logic               s1_valid;
  logic               s1_last;
  logic [PCNT_W-1:0]  s1_pcnt;
  logic [CLASS_W-1:0] s1_class;

  logic [DIST_W-1:0]  acc;
  logic [DIST_W-1:0]  best_int;
  logic [CLASS_W-1:0] best_class_int;
  logic [DIST_W-1:0]  sum;
  logic               best_upd;
  logic [DIST_W-1:0]  best_dist_next;
  logic [CLASS_W-1:0] best_class_next;
  logic               last_addr;

  function automatic logic [PCNT_W-1:0] popcount(input logic [FRAME_W-1:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < FRAME_W; i++) c = c + PCNT_W'(v[i]);
    return c;
  endfunction

  assign last_addr = (frame_id == LAST_CLASS) && (frame_index == LAST_FIDX);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Strict less-than keeps the earlier (lower) class on ties.
  always_comb begin
    sum             = acc + DIST_W'(s1_pcnt);
    best_upd        = s1_valid && s1_last && (sum < best_int);
    best_dist_next  = best_upd ? sum : best_int;
    best_class_next = best_upd ? s1_class : best_class_int;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_addr) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && query_wr_en &&
        ({1'b0, query_wr_idx} < (FIDX_W + 1)'(NUM_FRAMES)))
      query[query_wr_idx] <= query_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_id       <= '0;
      frame_index    <= '0;
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      s1_pcnt        <= '0;
      s1_class       <= '0;
      acc            <= '0;
      best_int       <= '1;
      best_class_int <= '0;
      best_class     <= '0;
      best_dist      <= '1;
    end else begin
      s1_valid <= (state == SCAN);
      s1_pcnt  <= popcount(class_vec_in ^ query[frame_index]);
      s1_last  <= (frame_index == LAST_FIDX);
      s1_class <= frame_id;

      if (s1_valid) begin
        best_int       <= best_dist_next;
        best_class_int <= best_class_next;
        acc            <= s1_last ? '0 : sum;
      end

      case (state)
        IDLE: if (start) begin
          frame_id    <= '0;
          frame_index <= '0;
          best_int    <= '1;
          acc         <= '0;
        end
        SCAN: begin
          if (last_addr) begin
            frame_id    <= '0;
            frame_index <= '0;
          end else if (frame_index == LAST_FIDX) begin
            frame_index <= '0;
            frame_id    <= frame_id + 1'b1;
          end else begin
            frame_index <= frame_index + 1'b1;
          end
        end
        // Outputs take the post-compare value so they are already valid while done is high.
        FLUSH: begin
          best_class <= best_class_next;
          best_dist  <= best_dist_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_class_search_ctrl.sv
// Directed bench for class_search_ctrl with a ROM model: class 3 is all ones,
// every other class all zeros.
module tb_class_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        query_wr_en;
  logic [1:0]  query_wr_idx;
  logic [63:0] query_wr_data;
  logic        start;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        busy;
  logic        done;
  logic [2:0]  best_class;
  logic [7:0]  best_dist;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign class_vec_in = (frame_id == 3'd3) ? '1 : '0;

  class_search_ctrl #(
    .NUM_CLASSES(8), .NUM_FRAMES(3), .FRAME_W(64),
    .CLASS_W(3), .FIDX_W(2), .DIST_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .query_wr_en(query_wr_en), .query_wr_idx(query_wr_idx), .query_wr_data(query_wr_data),
    .start(start), .frame_id(frame_id), .frame_index(frame_index),
    .class_vec_in(class_vec_in), .busy(busy), .done(done),
    .best_class(best_class), .best_dist(best_dist)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qwrite(input logic [1:0] idx, input logic [63:0] data);
    query_wr_en   = 1'b1;
    query_wr_idx  = idx;
    query_wr_data = data;
    tick();
    query_wr_en   = 1'b0;
  endtask

  // Caller is in cycle T; start is raised here. Optional pokes at T+poke_start / T+poke_wr.
  task automatic run_search(input int poke_start, input int poke_wr,
                            output int done_cyc, output int done_cnt,
                            output int addr_err, output int busy_err,
                            output logic [2:0] bc_at_done, output logic [7:0] bd_at_done);
    int exp_id, exp_idx;
    done_cyc = -1; done_cnt = 0; addr_err = 0; busy_err = 0;
    bc_at_done = 'x; bd_at_done = 'x;
    start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      start         = (n == poke_start);
      query_wr_en   = (n == poke_wr);
      query_wr_idx  = 2'd0;
      query_wr_data = 64'h1234;
      exp_id  = (n <= 24) ? (n - 1) / 3 : 0;
      exp_idx = (n <= 24) ? (n - 1) % 3 : 0;
      if (n <= 25 && (int'(frame_id) != exp_id || int'(frame_index) != exp_idx)) addr_err++;
      if (busy !== (n <= 26)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = n;
          bc_at_done = best_class;
          bd_at_done = best_dist;
        end
      end
    end
    start       = 1'b0;
    query_wr_en = 1'b0;
  endtask

  task automatic full_check(input string name, input int poke_start, input int poke_wr,
                            input logic [2:0] exp_bc, input logic [7:0] exp_bd);
    int dc, dn, ae, be;
    logic [2:0] bc;
    logic [7:0] bd;
    run_search(poke_start, poke_wr, dc, dn, ae, be, bc, bd);
    check({name, "_done_cycle"}, 64'(dc), 64'd26);
    check({name, "_done_count"}, 64'(dn), 64'd1);
    check({name, "_addr_sweep_errs"}, 64'(ae), 64'd0);
    check({name, "_busy_errs"}, 64'(be), 64'd0);
    check({name, "_class_at_done"}, 64'(bc), 64'(exp_bc));
    check({name, "_dist_at_done"}, 64'(bd), 64'(exp_bd));
    check({name, "_class_held"}, 64'(best_class), 64'(exp_bc));
    check({name, "_dist_held"}, 64'(best_dist), 64'(exp_bd));
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; query_wr_en = 1'b0;
    query_wr_idx = '0; query_wr_data = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_id", 64'(frame_id), 64'd0);
    check("rst_frame_index", 64'(frame_index), 64'd0);
    check("rst_best_class", 64'(best_class), 64'd0);
    check("rst_best_dist", 64'(best_dist), 64'hFF);
    rst = 1'b0;
    tick();

    // Query all ones; out-of-range slot 3 write must be dropped.
    qwrite(2'd0, '1); qwrite(2'd1, '1); qwrite(2'd2, '1); qwrite(2'd3, '0);
    full_check("ones", 0, 0, 3'd3, 8'd0);
    tick();

    // Query all zeros: classes other than 3 tie at 0, lowest id wins.
    qwrite(2'd0, '0); qwrite(2'd1, '0); qwrite(2'd2, '0);
    full_check("zeros", 0, 0, 3'd0, 8'd0);
    tick();

    // Frame 0 written in the same cycle as start: search must see it.
    query_wr_en = 1'b1; query_wr_idx = 2'd0; query_wr_data = '1;
    full_check("frame0", 0, 0, 3'd0, 8'd64);
    tick();

    // start at T+5 and a query write at T+6 while busy are both ignored.
    full_check("busy_pokes", 5, 6, 3'd0, 8'd64);
    tick();

    // Reset at T+10 of a search.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 2; n <= 10; n++) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_frame_id", 64'(frame_id), 64'd0);
    check("midrst_best_dist", 64'(best_dist), 64'hFF);
    check("midrst_best_class", 64'(best_class), 64'd0);
    rst = 1'b0;
    dn = 0;
    for (int n = 0; n < 30; n++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    full_check("after_rst", 0, 0, 3'd0, 8'd64);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/class_search_ctrl.md
Name: class_search_ctrl

Overview:
- Sequencer for the class-vector ROM (`class_vec_gen`) in the inference path.
- On `start`, walks every (class, frame) address of the ROM, one frame per cycle.
- Computes the Hamming distance between each ROM frame and a locally buffered query hypervector, accumulating per class.
- Reports the class with minimum total distance. It is the associative-search stage after encoding.

Parameters:
- NUM_CLASSES, 8, number of classes (ROM `frame_id` range 0..NUM_CLASSES-1).
- NUM_FRAMES, 3, frames per class (ROM `frame_index` range 0..NUM_FRAMES-1).
- FRAME_W, 64, bits per frame.
- CLASS_W, 3, width of class id, clog2(NUM_CLASSES).
- FIDX_W, 2, width of frame index, clog2(NUM_FRAMES).
- DIST_W, 8, distance width; must hold NUM_FRAMES*FRAME_W (192).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- query_wr_en  in  1  write one query frame into the internal buffer.
- query_wr_idx  in  FIDX_W  frame slot written; values >= NUM_FRAMES are ignored.
- query_wr_data  in  FRAME_W  query frame data.
- start  in  1  begin a search; sampled only in IDLE.
- frame_id  out  CLASS_W  ROM class address (registered).
- frame_index  out  FIDX_W  ROM frame address (registered).
- class_vec_in  in  FRAME_W  ROM data; combinational from frame_id/frame_index, same cycle.
- busy  out  1  high from the cycle after start until done inclusive.
- done  out  1  one-cycle pulse, results valid.
- best_class  out  CLASS_W  winning class, held until next done.
- best_dist  out  DIST_W  winning total distance, held until next done.

Behaviour:
- Reset values:
  - State IDLE; frame_id=0, frame_index=0, busy=0, done=0, best_class=0.
  - best_dist=all ones; accumulator=0; query buffer is not cleared.
- Query buffer: NUM_FRAMES x FRAME_W registers.
  - Written on query_wr_en only in IDLE; writes while busy are dropped.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - If start=1 in cycle T: addresses set to (0,0), internal best register set to all ones, accumulator cleared.
  - Go to SCAN at T+1.
- SCAN, one ROM frame per cycle:
  - Stage 1 registers popcount(class_vec_in XOR query[frame_index]), a last-frame flag (frame_index==NUM_FRAMES-1) and the class id.
  - Address advance: frame_index increments; at NUM_FRAMES-1 it wraps to 0 and frame_id increments.
  - When the address reaches (NUM_CLASSES-1, NUM_FRAMES-1), go to FLUSH; addresses return to 0.
  - SCAN lasts exactly NUM_CLASSES*NUM_FRAMES cycles (24).
- Stage 2, accumulate and compare, every cycle stage-1 data is valid:
  - sum = acc + popcount.
  - If last-frame flag: if sum < internal best (strict), update best and the class id; then acc=0. Otherwise acc=sum.
  - Ties keep the lower class id.
- FLUSH: one cycle draining the final stage-1 entry, then go to DONE.
- DONE: done=1 for one cycle; best_class/best_dist outputs load from the internal best; then go to IDLE.
- busy is high during SCAN, FLUSH and DONE.
- Latency: start sampled in cycle T gives done at T+NUM_CLASSES*NUM_FRAMES+2 (T+26).
- start while busy is ignored; no queueing.
- start and query_wr_en in the same IDLE cycle: the write lands first and the search uses the new data.
- rst mid-search: returns to IDLE immediately with reset values; no done pulse.
  - Previously reported best_class is lost; best_dist returns to all ones.
- Arithmetic: popcount width clog2(FRAME_W+1); accumulator and compare are DIST_W unsigned; overflow is impossible by parameter rule.

Test Plan:
- Bench ROM model returns all ones for class 3, all zeros otherwise; query all ones; start -> done at T+26, best_class=3, best_dist=0.
- Same ROM, query all zeros -> all-zero classes tie at 0; best_class=0 (lowest wins), best_dist=0.
- Same ROM, query frame0 = 64'hFFFF_FFFF_FFFF_FFFF, frames 1-2 zero -> class 3 dist 128, others 64; best_class=0, best_dist=64.
- Address sweep: log frame_id/frame_index during SCAN -> exactly (0,0),(0,1),(0,2),(1,0)...(7,2), 24 cycles, then (0,0).
- start pulsed at T+5 and query_wr_en at T+6 during a search -> no restart; query buffer unchanged; single done at T+26.
- rst asserted at T+10 of a search -> next cycle: busy=0, frame_id=0, best_dist=all ones; no done; a new start gives a correct result.
